// File: rtl/ingress_cdc.sv
// Ingress frame buffer: MAC RX words are held tentatively and published to the
// memory-side reader only on a good commit; bad, aborted or overflowed frames roll back.
module ingress_cdc #(
    parameter int DATA_DEPTH = 1024,
    parameter int LEN_DEPTH  = 32,
    parameter int LEN_WIDTH  = 14
) (
    input  logic                 clk_mem,
    input  logic                 rst_n,
    input  logic                 link_up,
    input  logic                 rx_start,
    input  logic                 rx_data_valid,
    input  logic [2:0]           rx_bytes_valid,
    input  logic [31:0]          rx_data,
    input  logic                 rx_commit,
    input  logic                 rx_drop,
    output logic                 frame_valid,
    output logic [LEN_WIDTH-1:0] frame_len,
    input  logic                 rd_en,
    output logic [31:0]          rd_data,
    output logic [2:0]           rd_bytes_valid,
    output logic                 rd_last,
    output logic                 rd_valid,
    output logic [15:0]          drop_count
);
    localparam int AW  = $clog2(DATA_DEPTH);
    localparam int LAW = $clog2(LEN_DEPTH);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

    typedef enum logic {ST_IDLE, ST_FRAME} rx_state_t;
    rx_state_t state, state_n;

    logic [34:0]          data_mem [DATA_DEPTH];
    logic [LEN_WIDTH-1:0] len_mem  [LEN_DEPTH];

    logic [AW:0]          wptr_tent, wptr_commit, rptr;
    logic [LAW:0]         len_wptr, len_rptr;
    logic [LEN_WIDTH-1:0] byte_cnt, byte_cnt_n;
    logic [LEN_WIDTH:0]   byte_sum;
    logic [LEN_WIDTH+1:0] rd_done;
    logic                 ovf;
    logic                 ram_full, len_full, len_empty;
    logic                 do_read, last_read, len_room;
    logic                 start_ev, commit_ok, rollback, rx_word, do_write;

    // Full compares the tentative writer against the reader so committed words are never overwritten.
    assign ram_full    = (wptr_tent ^ rptr) == {1'b1, {AW{1'b0}}};
    assign len_full    = (len_wptr ^ len_rptr) == {1'b1, {LAW{1'b0}}};
    assign len_empty   = (len_wptr == len_rptr);
    assign frame_valid = !len_empty;
    assign frame_len   = len_mem[len_rptr[LAW-1:0]];

    assign do_read   = rd_en && frame_valid;
    // Only the final word of a frame may be short, so a 4-byte stride finds the last word.
    assign last_read = (rd_done + (LEN_WIDTH+2)'(4)) >= {2'b00, frame_len};
    assign len_room  = !len_full || (do_read && last_read);

    assign byte_sum   = {1'b0, byte_cnt} + {{(LEN_WIDTH-2){1'b0}}, rx_bytes_valid};
    assign byte_cnt_n = byte_sum[LEN_WIDTH] ? LEN_MAX : byte_sum[LEN_WIDTH-1:0];

    always_comb begin
        state_n   = state;
        start_ev  = 1'b0;
        commit_ok = 1'b0;
        rollback  = 1'b0;
        rx_word   = 1'b0;
        do_write  = 1'b0;
        if (!link_up) begin
            rollback = (state == ST_FRAME);
            state_n  = ST_IDLE;
        end else if (rx_start) begin
            start_ev = 1'b1;
            state_n  = ST_FRAME;
        end else if (state == ST_FRAME) begin
            if (rx_commit) begin
                commit_ok = !ovf && len_room && (byte_cnt != '0) && (byte_cnt != LEN_MAX);
                rollback  = !commit_ok;
                state_n   = ST_IDLE;
            end else if (rx_drop) begin
                rollback = 1'b1;
                state_n  = ST_IDLE;
            end else if (rx_data_valid) begin
                rx_word  = 1'b1;
                do_write = !ram_full || do_read;
            end
        end
    end

    always_ff @(posedge clk_mem or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            wptr_tent      <= '0;
            wptr_commit    <= '0;
            rptr           <= '0;
            len_wptr       <= '0;
            len_rptr       <= '0;
            byte_cnt       <= '0;
            ovf            <= 1'b0;
            rd_done        <= '0;
            drop_count     <= '0;
            rd_valid       <= 1'b0;
            rd_last        <= 1'b0;
            rd_data        <= '0;
            rd_bytes_valid <= '0;
        end else begin
            state <= state_n;

            if (start_ev || rollback)
                wptr_tent <= wptr_commit;
            else if (do_write)
                wptr_tent <= wptr_tent + (AW+1)'(1);

            if (commit_ok) begin
                wptr_commit <= wptr_tent;
                len_wptr    <= len_wptr + (LAW+1)'(1);
            end

            if (start_ev) begin
                byte_cnt <= '0;
                ovf      <= 1'b0;
            end else if (do_write) begin
                byte_cnt <= byte_cnt_n;
            end else if (rx_word) begin
                ovf <= 1'b1;
            end

            if (rollback && drop_count != 16'hffff)
                drop_count <= drop_count + 16'd1;

            rd_valid <= do_read;
            rd_last  <= do_read && last_read;
            if (do_read) begin
                rptr                      <= rptr + (AW+1)'(1);
                {rd_bytes_valid, rd_data} <= data_mem[rptr[AW-1:0]];
                if (last_read) begin
                    rd_done  <= '0;
                    len_rptr <= len_rptr + (LAW+1)'(1);
                end else begin
                    rd_done <= rd_done + (LEN_WIDTH+2)'(4);
                end
            end
        end
    end

    // Storage arrays carry no reset; occupancy is tracked entirely by the pointers.
    always_ff @(posedge clk_mem) begin
        if (do_write)
            data_mem[wptr_tent[AW-1:0]] <= {rx_bytes_valid, rx_data};
        if (commit_ok)
            len_mem[len_wptr[LAW-1:0]] <= byte_cnt;
    end

endmodule

// File: tb/tb_ingress_cdc.sv
// Self-checking bench for ingress_cdc: a directed vector table, corner-case sequences
// and randomized frames, all compared against a frame-level queue model.
module tb_ingress_cdc;
    localparam int DATA_DEPTH = 1024;
    localparam int LEN_DEPTH  = 32;
    localparam int LEN_WIDTH  = 14;
    localparam int LEN_MAX    = (1 << LEN_WIDTH) - 1;

    logic                 clk_mem;
    logic                 rst_n;
    logic                 link_up;
    logic                 rx_start;
    logic                 rx_data_valid;
    logic [2:0]           rx_bytes_valid;
    logic [31:0]          rx_data;
    logic                 rx_commit;
    logic                 rx_drop;
    logic                 frame_valid;
    logic [LEN_WIDTH-1:0] frame_len;
    logic                 rd_en;
    logic [31:0]          rd_data;
    logic [2:0]           rd_bytes_valid;
    logic                 rd_last;
    logic                 rd_valid;
    logic [15:0]          drop_count;

    ingress_cdc #(
        .DATA_DEPTH(DATA_DEPTH),
        .LEN_DEPTH (LEN_DEPTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) dut (
        .clk_mem       (clk_mem),
        .rst_n         (rst_n),
        .link_up       (link_up),
        .rx_start      (rx_start),
        .rx_data_valid (rx_data_valid),
        .rx_bytes_valid(rx_bytes_valid),
        .rx_data       (rx_data),
        .rx_commit     (rx_commit),
        .rx_drop       (rx_drop),
        .frame_valid   (frame_valid),
        .frame_len     (frame_len),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_bytes_valid(rd_bytes_valid),
        .rd_last       (rd_last),
        .rd_valid      (rd_valid),
        .drop_count    (drop_count)
    );

    initial clk_mem = 1'b0;
    always #5 clk_mem = ~clk_mem;

    int checks = 0;
    int errors = 0;

    // Reference model: committed words and lengths as queues, the open frame as a list.
    logic [34:0] m_words[$];
    int          m_lens[$];
    logic [34:0] m_cur[$];
    bit          m_in;
    bit          m_ovf;
    int          m_bytes;
    int          m_rd_done;
    int          m_drops;
    bit          e_rv;
    logic [34:0] e_word;
    bit          e_last;

    typedef struct {
        logic                 st;
        logic                 dv;
        logic [2:0]           bv;
        logic [31:0]          d;
        logic                 cm;
        logic                 rd;
        logic                 efv;
        logic [LEN_WIDTH-1:0] elen;
        logic                 erv;
        logic [31:0]          ed;
        logic [2:0]           ebv;
        logic                 elast;
    } vec_t;
    vec_t vecs[12];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_abandon(input bit count_drop);
        if (count_drop && m_drops < 65535)
            m_drops++;
        m_cur.delete();
        m_in = 1'b0;
    endfunction

    function automatic void model_cycle(input logic lk, input logic st, input logic dv,
                                        input logic [2:0] bv, input logic [31:0] d,
                                        input logic cm, input logic dr, input logic rd);
        e_rv   = 1'b0;
        e_last = 1'b0;
        e_word = '0;
        if (rd && m_lens.size() > 0) begin
            e_rv      = 1'b1;
            e_word    = m_words.pop_front();
            m_rd_done += int'(e_word[34:32]);
            e_last    = (m_rd_done >= m_lens[0]);
            if (e_last) begin
                void'(m_lens.pop_front());
                m_rd_done = 0;
            end
        end
        if (!lk) begin
            if (m_in)
                model_abandon(1'b1);
        end else if (st) begin
            m_cur.delete();
            m_bytes = 0;
            m_ovf   = 1'b0;
            m_in    = 1'b1;
        end else if (m_in) begin
            if (cm) begin
                if (!m_ovf && m_lens.size() < LEN_DEPTH && m_bytes != 0 && m_bytes != LEN_MAX) begin
                    foreach (m_cur[i]) m_words.push_back(m_cur[i]);
                    m_lens.push_back(m_bytes);
                    model_abandon(1'b0);
                end else begin
                    model_abandon(1'b1);
                end
            end else if (dr) begin
                model_abandon(1'b1);
            end else if (dv) begin
                if (m_words.size() + m_cur.size() < DATA_DEPTH) begin
                    m_cur.push_back({bv, d});
                    m_bytes = (m_bytes + int'(bv) > LEN_MAX) ? LEN_MAX : m_bytes + int'(bv);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endfunction

    task automatic apply_stimulus(input logic lk, input logic st, input logic dv, input logic [2:0] bv,
                                  input logic [31:0] d, input logic cm, input logic dr, input logic rd);
        link_up        = lk;
        rx_start       = st;
        rx_data_valid  = dv;
        rx_bytes_valid = bv;
        rx_data        = d;
        rx_commit      = cm;
        rx_drop        = dr;
        rd_en          = rd;
        model_cycle(lk, st, dv, bv, d, cm, dr, rd);
        @(posedge clk_mem);
        #1;
        check_output("rd_valid", 64'(rd_valid), 64'(e_rv));
        if (e_rv) begin
            check_output("rd_data", 64'(rd_data), 64'(e_word[31:0]));
            check_output("rd_bytes_valid", 64'(rd_bytes_valid), 64'(e_word[34:32]));
            check_output("rd_last", 64'(rd_last), 64'(e_last));
        end
        check_output("frame_valid", 64'(frame_valid), 64'(m_lens.size() != 0));
        if (m_lens.size() != 0)
            check_output("frame_len", 64'(frame_len), 64'(m_lens[0]));
        check_output("drop_count", 64'(drop_count), 64'(m_drops));
        link_up       = 1'b1;
        rx_start      = 1'b0;
        rx_data_valid = 1'b0;
        rx_commit     = 1'b0;
        rx_drop       = 1'b0;
        rd_en         = 1'b0;
    endtask

    task automatic start_frame(input logic rd);
        apply_stimulus(1'b1, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, rd);
    endtask
    task automatic send_word(input logic [31:0] d, input logic [2:0] bv, input logic rd);
        apply_stimulus(1'b1, 1'b0, 1'b1, bv, d, 1'b0, 1'b0, rd);
    endtask
    task automatic commit_frame(input logic rd);
        apply_stimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0, rd);
    endtask
    task automatic drop_frame(input logic rd);
        apply_stimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, rd);
    endtask
    task automatic link_down(input logic cm);
        apply_stimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, cm, 1'b0, 1'b0);
    endtask
    task automatic read_word();
        apply_stimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 2 * DATA_DEPTH && m_lens.size() > 0; i++)
            read_word();
        check_output(name, 64'(frame_valid), 64'(0));
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        link_up        = 1'b1;
        rx_start       = 1'b0;
        rx_data_valid  = 1'b0;
        rx_bytes_valid = 3'd0;
        rx_data        = 32'h0;
        rx_commit      = 1'b0;
        rx_drop        = 1'b0;
        rd_en          = 1'b0;
        m_words.delete();
        m_lens.delete();
        m_cur.delete();
        m_in      = 1'b0;
        m_ovf     = 1'b0;
        m_bytes   = 0;
        m_rd_done = 0;
        m_drops   = 0;
        repeat (2) @(posedge clk_mem);
        #1;
        check_output("reset_frame_valid", 64'(frame_valid), 64'(0));
        check_output("reset_rd_valid", 64'(rd_valid), 64'(0));
        check_output("reset_rd_last", 64'(rd_last), 64'(0));
        check_output("reset_rd_data", 64'(rd_data), 64'(0));
        check_output("reset_drop_count", 64'(drop_count), 64'(0));
        rst_n = 1'b1;
        @(posedge clk_mem);
        #1;
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] w;
        logic [2:0]  bv;
        logic        r;
        int          nw;
        int          act;

        // st dv bv d cm rd | fv len rv data bv last
        vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 14'd0,  1'b0, 32'h0,        3'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 3'd4, 32'hfeedface, 1'b0, 1'b0, 1'b0, 14'd0,  1'b0, 32'h0,        3'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 3'd4, 32'hdeadbeef, 1'b0, 1'b0, 1'b0, 14'd0,  1'b0, 32'h0,        3'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'd4, 32'hcafef00d, 1'b0, 1'b0, 1'b0, 14'd0,  1'b0, 32'h0,        3'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 3'd4, 32'hbaadc0de, 1'b0, 1'b0, 1'b0, 14'd0,  1'b0, 32'h0,        3'd0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3'd3, 32'h41414100, 1'b0, 1'b0, 1'b0, 14'd0,  1'b0, 32'h0,        3'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 3'd0, 32'h0,        1'b1, 1'b0, 1'b1, 14'd19, 1'b0, 32'h0,        3'd0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 1'b1, 14'd19, 1'b1, 32'hfeedface, 3'd4, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 1'b1, 14'd19, 1'b1, 32'hdeadbeef, 3'd4, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 1'b1, 14'd19, 1'b1, 32'hcafef00d, 3'd4, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 1'b1, 14'd19, 1'b1, 32'hbaadc0de, 3'd4, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 1'b0, 14'd0,  1'b1, 32'h41414100, 3'd3, 1'b1};

        do_reset();
        $display("[TB] basic frame vectors");
        foreach (vecs[i]) begin
            apply_stimulus(1'b1, vecs[i].st, vecs[i].dv, vecs[i].bv, vecs[i].d, vecs[i].cm, 1'b0, vecs[i].rd);
            check_output($sformatf("vec%0d_frame_valid", i), 64'(frame_valid), 64'(vecs[i].efv));
            if (vecs[i].efv)
                check_output($sformatf("vec%0d_frame_len", i), 64'(frame_len), 64'(vecs[i].elen));
            check_output($sformatf("vec%0d_rd_valid", i), 64'(rd_valid), 64'(vecs[i].erv));
            if (vecs[i].erv) begin
                check_output($sformatf("vec%0d_rd_data", i), 64'(rd_data), 64'(vecs[i].ed));
                check_output($sformatf("vec%0d_rd_bytes", i), 64'(rd_bytes_valid), 64'(vecs[i].ebv));
                check_output($sformatf("vec%0d_rd_last", i), 64'(rd_last), 64'(vecs[i].elast));
            end
        end

        $display("[TB] dropped frame then full-depth frame");
        do_reset();
        start_frame(1'b0);
        for (int i = 0; i < 5; i++) send_word(32'h1000_0000 + 32'(i), 3'd4, 1'b0);
        drop_frame(1'b0);
        check_output("drop_count_after_drop", 64'(drop_count), 64'(1));
        check_output("frame_valid_after_drop", 64'(frame_valid), 64'(0));
        start_frame(1'b0);
        for (int i = 0; i < DATA_DEPTH; i++) send_word($urandom, 3'd4, 1'b0);
        commit_frame(1'b0);
        check_output("full_depth_len", 64'(frame_len), 64'(DATA_DEPTH * 4));
        drain("full_depth_drained");

        $display("[TB] link loss, commit collision, empty and restarted frames");
        do_reset();
        start_frame(1'b0);
        send_word(32'haaaa_aaaa, 3'd4, 1'b0);
        send_word(32'hbbbb_bbbb, 3'd4, 1'b0);
        link_down(1'b0);
        start_frame(1'b0);
        send_word(32'h1111_1111, 3'd4, 1'b0);
        send_word(32'h2222_0000, 3'd2, 1'b0);
        commit_frame(1'b0);
        check_output("link_drop_count", 64'(drop_count), 64'(1));
        check_output("link_second_len", 64'(frame_len), 64'(6));
        read_word();
        check_output("link_first_word", 64'(rd_data), 64'(32'h1111_1111));
        read_word();
        start_frame(1'b0);
        send_word(32'h3333_3333, 3'd4, 1'b0);
        link_down(1'b1);
        check_output("collision_frame_valid", 64'(frame_valid), 64'(0));
        start_frame(1'b0);
        commit_frame(1'b0);
        check_output("empty_commit_drops", 64'(drop_count), 64'(3));
        start_frame(1'b0);
        send_word(32'h4444_4444, 3'd4, 1'b0);
        start_frame(1'b0);
        send_word(32'h5555_5555, 3'd4, 1'b0);
        commit_frame(1'b0);
        check_output("restart_len", 64'(frame_len), 64'(4));
        check_output("restart_no_drop", 64'(drop_count), 64'(3));
        drain("restart_drained");

        $display("[TB] data overflow");
        do_reset();
        start_frame(1'b0);
        for (int i = 0; i < DATA_DEPTH + 1; i++) send_word($urandom, 3'd4, 1'b0);
        commit_frame(1'b0);
        check_output("overflow_dropped", 64'(drop_count), 64'(1));
        check_output("overflow_no_frame", 64'(frame_valid), 64'(0));
        start_frame(1'b0);
        send_word(32'h0102_0304, 3'd4, 1'b0);
        send_word(32'h0506_0708, 3'd4, 1'b0);
        send_word(32'h090a_0000, 3'd2, 1'b0);
        commit_frame(1'b0);
        check_output("after_overflow_len", 64'(frame_len), 64'(10));
        drain("after_overflow_drained");

        $display("[TB] length fifo overflow");
        do_reset();
        for (int i = 0; i < LEN_DEPTH + 1; i++) begin
            start_frame(1'b0);
            send_word(32'hc0de_0000 + 32'(i), 3'(1 + i % 4), 1'b0);
            commit_frame(1'b0);
        end
        check_output("len_fifo_drop", 64'(drop_count), 64'(1));
        check_output("len_fifo_head_len", 64'(frame_len), 64'(1));
        drain("len_fifo_drained");

        $display("[TB] concurrent read and write");
        do_reset();
        start_frame(1'b0);
        for (int i = 0; i < 8; i++) send_word($urandom, 3'd4, 1'b0);
        commit_frame(1'b0);
        start_frame(1'b1);
        for (int i = 0; i < 8; i++) send_word($urandom, (i == 7) ? 3'd1 : 3'd4, 1'b1);
        commit_frame(1'b1);
        drain("concurrent_drained");

        $display("[TB] randomized frames");
        do_reset();
        for (int f = 0; f < 80; f++) begin
            nw  = $urandom_range(1, 20);
            act = $urandom_range(0, 99);
            r   = 1'($urandom_range(0, 1));
            start_frame(r);
            for (int i = 0; i < nw; i++) begin
                w  = $urandom;
                bv = (i == nw - 1) ? 3'($urandom_range(1, 4)) : 3'd4;
                r  = 1'($urandom_range(0, 1));
                send_word(w, bv, r);
            end
            r = 1'($urandom_range(0, 1));
            if (act < 75)      commit_frame(r);
            else if (act < 87) drop_frame(r);
            else if (act < 94) link_down(1'b0);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                r = 1'($urandom_range(0, 1));
                apply_stimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, r);
            end
        end
        commit_frame(1'b0);
        drain("random_drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
